avl_mem_responder: RTL and testbench

//  Avalon-MM agent (slave) that terminates the bus driven by our Avalon-MM host bridges and

---
 rtl/avl_mem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_avl_mem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_mem_responder.sv
// rtl/avl_mem_responder.sv - Avalon-MM agent backed by an internal word-addressed RAM
// Pipelined reads, incrementing bursts and write responses; responses leave strictly in command order.
module avl_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int MAX_PEND   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_avl_address_i,
    input  logic [3:0]  s_avl_byteenable_i,
    input  logic        s_avl_lock_i,
    input  logic        s_avl_read_i,
    input  logic [31:0] s_avl_writedata_i,
    input  logic        s_avl_write_i,
    input  logic [2:0]  s_avl_burstcount_i,
    output logic [31:0] s_avl_readdata_o,
    output logic [1:0]  s_avl_response_o,
    output logic        s_avl_waitrequest_o,
    output logic        s_avl_readdatavalid_o,
    output logic        s_avl_writeresponsevalid_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RBURST = 2'd1;
    localparam logic [1:0] ST_WBURST = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [31:0] mem [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] base_q, base_d;
    logic [2:0]            beat_q, beat_d;
    logic [2:0]            len_q, len_d;
    logic [1:0]            err_q, err_d;

    // Stage 1: registered RAM read plus the response it belongs to.
    logic        s1_valid_q, s1_valid_d;
    logic        s1_wr_q, s1_wr_d;
    logic [1:0]  s1_resp_q, s1_resp_d;
    logic [31:0] s1_rdata_q;

    logic        rd_valid_q, wr_valid_q;
    logic [31:0] rdata_q;
    logic [1:0]  resp_q;

    logic [2:0]            cmd_len;
    logic [1:0]            cmd_resp;
    logic [DEPTH_LOG2-1:0] cmd_idx;
    logic [DEPTH_LOG2-1:0] beat_idx;
    logic                  credit_ok;
    logic                  ram_rd, ram_wr;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  unused_lock;

    assign unused_lock = s_avl_lock_i;

    assign cmd_len  = (s_avl_burstcount_i == 3'd0) ? 3'd1 : s_avl_burstcount_i;
    assign cmd_idx  = s_avl_address_i[DEPTH_LOG2+1:2];
    assign beat_idx = base_q + DEPTH_LOG2'(beat_q);

    always_comb begin
        cmd_resp = RESP_OKAY;
        if (s_avl_address_i[31:DEPTH_LOG2+2] != '0) begin
            cmd_resp = RESP_DECERR;
        end else if (s_avl_address_i[1:0] != 2'b00) begin
            cmd_resp = RESP_SLVERR;
        end
    end

    // Everything issued but not yet presented, plus the beat being presented now.
    assign credit_ok = (int'(s1_valid_q) + int'(rd_valid_q | wr_valid_q)) < MAX_PEND;

    assign s_avl_waitrequest_o = !rst || (state_q == ST_RBURST) || !credit_ok;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        beat_d     = beat_q;
        len_d      = len_q;
        err_d      = err_q;
        ram_rd     = 1'b0;
        ram_wr     = 1'b0;
        ram_idx    = cmd_idx;
        s1_valid_d = 1'b0;
        s1_wr_d    = 1'b0;
        s1_resp_d  = cmd_resp;
        case (state_q)
            ST_IDLE: begin
                if (s_avl_read_i && !s_avl_waitrequest_o) begin
                    ram_rd     = 1'b1;
                    s1_valid_d = 1'b1;
                    if (cmd_len > 3'd1) begin
                        state_d = ST_RBURST;
                        base_d  = cmd_idx;
                        beat_d  = 3'd1;
                        len_d   = cmd_len;
                        err_d   = cmd_resp;
                    end
                end else if (s_avl_write_i && !s_avl_waitrequest_o) begin
                    ram_wr = (cmd_resp == RESP_OKAY);
                    if (cmd_len > 3'd1) begin
                        state_d = ST_WBURST;
                        base_d  = cmd_idx;
                        beat_d  = 3'd1;
                        len_d   = cmd_len;
                        err_d   = cmd_resp;
                    end else begin
                        s1_valid_d = 1'b1;
                        s1_wr_d    = 1'b1;
                    end
                end
            end
            ST_RBURST: begin
                if (credit_ok) begin
                    ram_rd     = 1'b1;
                    ram_idx    = beat_idx;
                    s1_valid_d = 1'b1;
                    s1_resp_d  = err_q;
                    if (beat_q == len_q - 3'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            ST_WBURST: begin
                // Address and read are ignored here; beats continue from the burst start.
                if (s_avl_write_i && !s_avl_waitrequest_o) begin
                    ram_wr  = (err_q == RESP_OKAY);
                    ram_idx = beat_idx;
                    if (beat_q == len_q - 3'd1) begin
                        state_d    = ST_IDLE;
                        s1_valid_d = 1'b1;
                        s1_wr_d    = 1'b1;
                        s1_resp_d  = err_q;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM has no reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (s_avl_byteenable_i[b]) begin
                    mem[ram_idx][8*b +: 8] <= s_avl_writedata_i[8*b +: 8];
                end
            end
        end
        if (ram_rd) begin
            s1_rdata_q <= mem[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            beat_q     <= 3'd0;
            len_q      <= 3'd1;
            err_q      <= RESP_OKAY;
            s1_valid_q <= 1'b0;
            s1_wr_q    <= 1'b0;
            s1_resp_q  <= RESP_OKAY;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rdata_q    <= 32'd0;
            resp_q     <= RESP_OKAY;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            err_q      <= err_d;
            s1_valid_q <= s1_valid_d;
            s1_wr_q    <= s1_wr_d;
            s1_resp_q  <= s1_resp_d;
            rd_valid_q <= s1_valid_q && !s1_wr_q;
            wr_valid_q <= s1_valid_q && s1_wr_q;
            if (s1_valid_q) begin
                resp_q <= s1_resp_q;
                if (!s1_wr_q) begin
                    rdata_q <= (s1_resp_q == RESP_OKAY) ? s1_rdata_q : 32'd0;
                end
            end
        end
    end

    assign s_avl_readdata_o           = rdata_q;
    assign s_avl_response_o           = resp_q;
    assign s_avl_readdatavalid_o      = rd_valid_q;
    assign s_avl_writeresponsevalid_o = wr_valid_q;

endmodule

// File: tb/tb_avl_mem_responder.sv
// tb/tb_avl_mem_responder.sv - directed self-checking bench for avl_mem_responder
module tb_avl_mem_responder;
    localparam int MAX_PEND = 4;
    localparam int TMO      = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] avl_addr;
    logic [3:0]  avl_be;
    logic        avl_lock;
    logic        avl_read;
    logic [31:0] avl_wdata;
    logic        avl_write;
    logic [2:0]  avl_bc;
    logic [31:0] dut_rdata;
    logic [1:0]  dut_resp;
    logic        dut_wait;
    logic        dut_rdv;
    logic        dut_wrv;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int ev_seen   = 0;
    int both_hi   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          cyc;
    } ev_t;

    ev_t evq[$];
    ev_t col_e;

    logic [31:0] t4_addr [6] = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h10, 32'h20};
    logic [31:0] t4_exp  [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'hDE22BE44, 32'd1};

    avl_mem_responder #(.DEPTH_LOG2(10), .MAX_PEND(MAX_PEND)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .s_avl_address_i            (avl_addr),
        .s_avl_byteenable_i         (avl_be),
        .s_avl_lock_i               (avl_lock),
        .s_avl_read_i               (avl_read),
        .s_avl_writedata_i          (avl_wdata),
        .s_avl_write_i              (avl_write),
        .s_avl_burstcount_i         (avl_bc),
        .s_avl_readdata_o           (dut_rdata),
        .s_avl_response_o           (dut_resp),
        .s_avl_waitrequest_o        (dut_wait),
        .s_avl_readdatavalid_o      (dut_rdv),
        .s_avl_writeresponsevalid_o (dut_wrv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dut_rdv === 1'b1 || dut_wrv === 1'b1) begin
            col_e.wr   = (dut_wrv === 1'b1);
            col_e.data = dut_rdata;
            col_e.resp = dut_resp;
            col_e.cyc  = cyc;
            evq.push_back(col_e);
            ev_seen++;
        end
        if (dut_rdv === 1'b1 && dut_wrv === 1'b1) both_hi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic bus_cmd(input logic rd, input logic wr, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d, input logic [2:0] bc, output int acc);
        int n;
        avl_read  = rd;
        avl_write = wr;
        avl_addr  = a;
        avl_be    = be;
        avl_wdata = d;
        avl_bc    = bc;
        n = 0;
        #1;
        while (dut_wait !== 1'b0 && n < TMO) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= TMO) check("cmd_accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        acc       = cyc;
        avl_read  = 1'b0;
        avl_write = 1'b0;
    endtask

    task automatic get_resp(output ev_t e);
        int n;
        n = 0;
        while (evq.size() == 0 && n < TMO) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (evq.size() == 0) begin
            check("resp_timeout", 32'(n), 32'd0);
            e.wr   = 1'bx;
            e.data = 'x;
            e.resp = 'x;
            e.cyc  = -100;
        end else begin
            e = evq.pop_front();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t e;
        ev_t rb [4];
        int  acc;
        int  n;
        int  acc_n;
        int  seen0;
        int  infl_max;

        rst       = 1'b0;
        avl_addr  = 32'd0;
        avl_be    = 4'd0;
        avl_lock  = 1'b0;
        avl_read  = 1'b0;
        avl_wdata = 32'd0;
        avl_write = 1'b0;
        avl_bc    = 3'd1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_waitrequest", 32'(dut_wait), 32'd1);
        check("rst_readdatavalid", 32'(dut_rdv), 32'd0);
        check("rst_writeresponsevalid", 32'(dut_wrv), 32'd0);
        check("rst_readdata", dut_rdata, 32'd0);
        check("rst_response", 32'(dut_resp), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("idle_waitrequest", 32'(dut_wait), 32'd0);

        // 1: single write then single read; response sampled by host two edges after accept
        bus_cmd(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 3'd1, acc);
        get_resp(e);
        check("t1_wr_is_write", 32'(e.wr), 32'd1);
        check("t1_wr_resp", 32'(e.resp), 32'd0);
        check("t1_wr_latency", 32'(e.cyc - acc), 32'd1);
        bus_cmd(1'b1, 1'b0, 32'h10, 4'h0, 32'd0, 3'd1, acc);
        get_resp(e);
        check("t1_rd_is_read", 32'(e.wr), 32'd0);
        check("t1_rd_data", e.data, 32'hDEADBEEF);
        check("t1_rd_resp", 32'(e.resp), 32'd0);
        check("t1_rd_latency", 32'(e.cyc - acc), 32'd1);

        // 2: partial byte-enable overwrite
        bus_cmd(1'b0, 1'b1, 32'h10, 4'b0101, 32'h11223344, 3'd1, acc);
        get_resp(e);
        check("t2_wr_resp", 32'(e.resp), 32'd0);
        bus_cmd(1'b1, 1'b0, 32'h10, 4'h0, 32'd0, 3'd1, acc);
        get_resp(e);
        check("t2_rd_data", e.data, 32'hDE22BE44);

        // 3: write burst of 4 then read burst of 4
        for (int i = 0; i < 4; i++) begin
            bus_cmd(1'b0, 1'b1, 32'h20, 4'hF, 32'(i + 1), 3'd4, acc);
        end
        get_resp(e);
        check("t3_wr_is_write", 32'(e.wr), 32'd1);
        check("t3_wr_resp", 32'(e.resp), 32'd0);
        check("t3_wr_latency", 32'(e.cyc - acc), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("t3_single_wr_resp", 32'(evq.size()), 32'd0);
        bus_cmd(1'b1, 1'b0, 32'h20, 4'h0, 32'd0, 3'd4, acc);
        #1;
        check("t3_wait_during_issue", 32'(dut_wait), 32'd1);
        for (int i = 0; i < 4; i++) begin
            get_resp(rb[i]);
            check($sformatf("t3_rd_data_%0d", i), rb[i].data, 32'(i + 1));
        end
        check("t3_rd_first_latency", 32'(rb[0].cyc - acc), 32'd1);
        check("t3_rd_consecutive", 32'(rb[3].cyc - rb[0].cyc), 32'd3);

        // 4: six back-to-back single reads
        avl_read = 1'b1;
        avl_be   = 4'h0;
        avl_bc   = 3'd1;
        seen0    = ev_seen;
        acc_n    = 0;
        infl_max = 0;
        for (int i = 0; i < 6; i++) begin
            avl_addr = t4_addr[i];
            n = 0;
            while (dut_wait !== 1'b0 && n < TMO) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (n >= TMO) check("t4_accept_timeout", 32'(n), 32'd0);
            if (acc_n + 1 - (ev_seen - seen0) > infl_max) infl_max = acc_n + 1 - (ev_seen - seen0);
            @(posedge clk);
            @(negedge clk);
            #1;
            acc_n++;
        end
        avl_read = 1'b0;
        for (int i = 0; i < 6; i++) begin
            get_resp(e);
            check($sformatf("t4_rd_data_%0d", i), e.data, t4_exp[i]);
        end
        check("t4_credit_respected", 32'(infl_max <= MAX_PEND), 32'd1);
        check("t4_none_lost", 32'(ev_seen - seen0), 32'd6);

        // 5: decode / slave errors
        bus_cmd(1'b0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 3'd1, acc);
        get_resp(e);
        check("t5_seed_resp", 32'(e.resp), 32'd0);
        bus_cmd(1'b1, 1'b0, 32'h0000_1000, 4'h0, 32'd0, 3'd1, acc);
        get_resp(e);
        check("t5_decerr_resp", 32'(e.resp), 32'd3);
        check("t5_decerr_data", e.data, 32'd0);
        bus_cmd(1'b1, 1'b0, 32'h0000_1002, 4'h0, 32'd0, 3'd1, acc);
        get_resp(e);
        check("t5_decerr_priority", 32'(e.resp), 32'd3);
        bus_cmd(1'b0, 1'b1, 32'h2, 4'hF, 32'hFFFFFFFF, 3'd1, acc);
        get_resp(e);
        check("t5_slverr_is_write", 32'(e.wr), 32'd1);
        check("t5_slverr_resp", 32'(e.resp), 32'd2);
        bus_cmd(1'b1, 1'b0, 32'h0, 4'h0, 32'd0, 3'd1, acc);
        get_resp(e);
        check("t5_ram_unchanged", e.data, 32'hCAFEF00D);

        // 6: reset in the middle of a read burst
        bus_cmd(1'b1, 1'b0, 32'h20, 4'h0, 32'd0, 3'd4, acc);
        get_resp(e);
        check("t6_beat0_data", e.data, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("t6_rst_rdv", 32'(dut_rdv), 32'd0);
        check("t6_rst_wrv", 32'(dut_wrv), 32'd0);
        check("t6_rst_wait", 32'(dut_wait), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("t6_no_stale", 32'(evq.size()), 32'd0);
        bus_cmd(1'b1, 1'b0, 32'h24, 4'h0, 32'd0, 3'd1, acc);
        get_resp(e);
        check("t6_ram_kept", e.data, 32'd2);
        check("t6_ram_kept_resp", 32'(e.resp), 32'd0);

        check("never_both_valid", 32'(both_hi), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
